// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 RAM controller sequencer: mode encodings,
// sequencer state type and the phase-to-mode mapping.
package rc4_pkg;

  localparam logic [2:0] MODE_IDLE    = 3'b000;
  localparam logic [2:0] MODE_INIT    = 3'b001;
  localparam logic [2:0] MODE_SHUFFLE = 3'b010;
  localparam logic [2:0] MODE_DECRYPT = 3'b011;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    START   = 3'd2,
    WAIT    = 3'd3,
    DONE_ST = 3'd4,
    ERROR   = 3'd5
  } seq_state_t;

  // Phase i drives controller mode i+1 (phase 0 -> MODE_INIT).
  function automatic logic [2:0] phase_mode(input logic [2:0] ph);
    return MODE_INIT + ph;
  endfunction

endpackage

// File: rtl/phase_watchdog.sv
// Per-phase watchdog: loadable down-counter. Loaded on clear, counts down
// while enabled and flags expiry on the enabled cycle where the count is zero,
// i.e. on the TIMEOUT_CYCLES-th enabled cycle after a clear.
module phase_watchdog #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TMO_W          = 13
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TMO_W-1:0] cnt_q;
  logic [TMO_W-1:0] cnt_d;

  // Reload on clear, otherwise count down while enabled and hold at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = TMO_W'(TIMEOUT_CYCLES - 1);
    end else if (enable && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = enable && (cnt_q == '0);

endmodule

// File: rtl/rc4_phase_sequencer.sv
// Top-level RC4 job sequencer: runs init -> shuffle -> decrypt, one phase at a
// time. Each phase presents its mode for one cycle, pulses start, then waits
// for a fresh rising finished flag from the controller. All outputs registered.
module rc4_phase_sequencer
  import rc4_pkg::*;
#(
  parameter int RAM_WIDTH      = 8,
  parameter int KEY_LENGTH     = 3,
  parameter int NUM_PHASES     = 3,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TMO_W          = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             go,
  input  logic                             abort,
  input  logic [KEY_LENGTH*RAM_WIDTH-1:0]  key_in,
  input  logic [NUM_PHASES-1:0]            finished,
  output logic [KEY_LENGTH*RAM_WIDTH-1:0]  key,
  output logic [2:0]                       mode,
  output logic                             start,
  output logic [2:0]                       phase,
  output logic                             busy,
  output logic                             done,
  output logic                             error
);

  localparam int KW = KEY_LENGTH * RAM_WIDTH;

  seq_state_t    state_q, state_d;
  logic [2:0]    phase_q, phase_d;
  logic [2:0]    mode_q, mode_d;
  logic          start_q, start_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic          armed_q, armed_d;
  logic [KW-1:0] key_q, key_d;

  logic [7:0]    fin_ext;
  logic          fin_sel;
  logic          go_acc;
  logic          complete;
  logic          last_phase;
  logic          expired;

  // Only the flag of the active phase matters; others are ignored.
  assign fin_ext    = 8'(finished);
  assign fin_sel    = fin_ext[phase_q];
  assign go_acc     = go && !abort &&
                      ((state_q == IDLE) || (state_q == DONE_ST) || (state_q == ERROR));
  // Completion requires having seen the flag low first, so a flag left high
  // by an earlier run cannot end this phase early.
  assign complete   = (state_q == WAIT) && armed_q && fin_sel;
  assign last_phase = (phase_q == 3'(NUM_PHASES - 1));

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_wdog
      phase_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .TMO_W         (TMO_W)
      ) u_wdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (state_q == START),
        .enable (state_q == WAIT),
        .expired(expired)
      );
    end else begin : g_no_wdog
      assign expired = 1'b0;
    end
  endgenerate

  // State, phase, arm flag, key and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      phase_q <= '0;
      armed_q <= 1'b0;
      key_q   <= '0;
      mode_q  <= MODE_IDLE;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      armed_q <= armed_d;
      key_q   <= key_d;
      mode_q  <= mode_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  // Next-state: abort wins over everything; completion wins over timeout.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    armed_d = armed_q;
    key_d   = key_q;
    if (abort) begin
      state_d = IDLE;
      phase_d = '0;
    end else if (go_acc) begin
      state_d = SETUP;
      phase_d = '0;
      key_d   = key_in;
    end else begin
      case (state_q)
        SETUP: state_d = START;
        START: begin
          state_d = WAIT;
          armed_d = 1'b0;
        end
        WAIT: begin
          if (complete) begin
            if (last_phase) begin
              state_d = DONE_ST;
              phase_d = '0;
            end else begin
              state_d = SETUP;
              phase_d = phase_q + 3'd1;
            end
          end else begin
            if (!fin_sel) armed_d = 1'b1;
            if (expired) begin
              state_d = ERROR;
              phase_d = '0;
            end
          end
        end
        DONE_ST: state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  // Outputs decoded from the next state so they line up with the state register.
  always_comb begin
    start_d = (state_d == START);
    busy_d  = (state_d == SETUP) || (state_d == START) || (state_d == WAIT);
    done_d  = (state_d == DONE_ST);
    mode_d  = busy_d ? phase_mode(phase_d) : MODE_IDLE;
    error_d = error_q;
    if (go_acc) begin
      error_d = 1'b0;
    end else if (state_d == ERROR) begin
      error_d = 1'b1;
    end
  end

  assign key   = key_q;
  assign mode  = mode_q;
  assign start = start_q;
  assign phase = phase_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign error = error_q;

endmodule

// File: tb/tb_rc4_phase_sequencer.sv
// Bench for rc4_phase_sequencer: job-level behavioural model plus a simple
// reactive controller that raises finished a fixed or random time after start.
module tb_rc4_phase_sequencer;

  localparam int NP  = 3;
  localparam int TMO = 16;
  localparam int KW  = 24;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          go = 1'b0;
  logic          abort = 1'b0;
  logic [KW-1:0] key_in = '0;
  logic [NP-1:0] finished;
  logic [KW-1:0] key;
  logic [2:0]    mode;
  logic          start;
  logic [2:0]    phase;
  logic          busy;
  logic          done;
  logic          error;

  int vectors = 0;
  int miscompares = 0;

  // Controller stand-in
  bit            resp_en = 1'b0;
  bit            resp_lat_rand = 1'b0;
  logic [NP-1:0] resp_fin = '0;
  logic [NP-1:0] man_fin = '0;
  logic [NP-1:0] resp_block = '0;
  int            resp_cnt = 0;
  int            resp_idx = 0;

  assign finished = resp_en ? resp_fin : man_fin;

  always #5 clk = ~clk;

  rc4_phase_sequencer #(
    .RAM_WIDTH     (8),
    .KEY_LENGTH    (3),
    .NUM_PHASES    (NP),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk     (clk),
    .reset   (rst_n),
    .go      (go),
    .abort   (abort),
    .key_in  (key_in),
    .finished(finished),
    .key     (key),
    .mode    (mode),
    .start   (start),
    .phase   (phase),
    .busy    (busy),
    .done    (done),
    .error   (error)
  );

  // Job-level model: stage 0 idle, 1 running, 2 done pulse, 3 error.
  // Within a running phase, step 0 = mode presented, 1 = start, 2 = waiting.
  int          m_stage = 0;
  int          m_ph = 0;
  int          m_step = 0;
  int          m_wcnt = 0;
  bit          m_arm = 1'b0;
  bit          m_err = 1'b0;
  logic [KW-1:0] m_key = '0;

  always @(posedge clk or negedge rst_n) begin
    int st, ph, step, wc;
    bit arm, er;
    logic [KW-1:0] k;
    if (!rst_n) begin
      m_stage <= 0; m_ph <= 0; m_step <= 0; m_wcnt <= 0;
      m_arm <= 1'b0; m_err <= 1'b0; m_key <= '0;
    end else begin
      st = m_stage; ph = m_ph; step = m_step; wc = m_wcnt;
      arm = m_arm; er = m_err; k = m_key;
      if (abort) begin
        st = 0;
      end else if (go && st != 1) begin
        st = 1; ph = 0; step = 0; k = key_in; er = 1'b0;
      end else if (st == 1) begin
        if (step == 0) begin
          step = 1;
        end else if (step == 1) begin
          step = 2; arm = 1'b0; wc = 0;
        end else begin
          wc = wc + 1;
          if (arm && finished[ph]) begin
            if (ph < NP - 1) begin
              ph = ph + 1; step = 0;
            end else begin
              st = 2;
            end
          end else begin
            if (!finished[ph]) arm = 1'b1;
            if (wc == TMO) begin
              st = 3; er = 1'b1;
            end
          end
        end
      end else if (st == 2) begin
        st = 0;
      end
      m_stage <= st; m_ph <= ph; m_step <= step; m_wcnt <= wc;
      m_arm <= arm; m_err <= er; m_key <= k;
    end
  end

  function automatic logic [33:0] model_vec();
    bit run;
    run = (m_stage == 1);
    return {m_key,
            run ? 3'(m_ph + 1) : 3'd0,
            run ? 3'(m_ph) : 3'd0,
            run && (m_step == 1),
            run,
            m_stage == 2,
            m_err};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: compare against the model, then let the controller react.
  task automatic tick();
    @(posedge clk);
    #1;
    chk("outputs{key,mode,phase,start,busy,done,error}",
        {key, mode, phase, start, busy, done, error}, model_vec());
    if (resp_en) begin
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0 && !resp_block[resp_idx]) resp_fin[resp_idx] = 1'b1;
      end
      if (start && mode >= 3'd1 && mode <= 3'(NP)) begin
        resp_idx = int'(mode) - 1;
        resp_fin[resp_idx] = 1'b0;
        resp_cnt = resp_lat_rand ? int'($urandom_range(2, 22)) : 10;
      end
    end
  endtask

  task automatic wait_start_mode(input logic [2:0] m, input string name);
    int n;
    n = 0;
    while (!(start && mode == m) && n < 100) begin tick(); n++; end
    if (n >= 100) chk(name, 0, 1);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 100) begin tick(); n++; end
    if (n >= 100) chk(name, 0, 1);
  endtask

  initial begin
    int n;
    // Reset held with go toggling
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      go = i[0];
      key_in = 24'hABCDEF;
      tick();
    end
    chk("reset_mode", mode, 3'b000);
    chk("reset_busy_start_done_error", {busy, start, done, error}, 4'b0000);
    chk("reset_key", key, 24'h0);
    go = 1'b0;
    rst_n = 1'b1;
    tick(); tick();
    chk("idle_after_reset", {busy, start, mode, phase}, 8'h00);

    // Nominal job
    resp_en = 1'b1; resp_fin = '0;
    key_in = 24'h030201; go = 1'b1;
    tick();
    go = 1'b0; key_in = 24'hFFFFFF;
    chk("nom_setup_mode", mode, 3'b001);
    chk("nom_setup_start", start, 1'b0);
    chk("nom_busy", busy, 1'b1);
    chk("nom_key", key, 24'h030201);
    tick();
    chk("nom_first_start", {start, mode}, 4'b1001);
    n = 0;
    while (!done && n < 60) begin tick(); n++; end
    chk("nom_done_latency", n, 35);
    chk("nom_key_held", key, 24'h030201);
    tick();
    chk("nom_after_done", {done, busy, mode}, 5'b00000);

    // Back-to-back: go in the done cycle
    key_in = 24'h112233; go = 1'b1;
    tick();
    go = 1'b0;
    wait_done("b2b_first_done_timeout");
    key_in = 24'h0A0B0C; go = 1'b1;
    tick();
    go = 1'b0;
    chk("b2b_mode", mode, 3'b001);
    chk("b2b_key", key, 24'h0A0B0C);
    chk("b2b_busy_phase", {busy, phase}, 4'b1000);
    wait_done("b2b_second_done_timeout");
    tick();

    // Stale finished flags
    resp_en = 1'b0; man_fin = 3'b111;
    go = 1'b1;
    tick();
    go = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("stale_phase_held", {phase, mode, busy}, 7'b0000011);
    man_fin = 3'b110;
    tick();
    man_fin = 3'b111;
    tick();
    chk("stale_advance", {phase, mode}, 6'b001010);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();

    // Timeout in phase 1
    resp_en = 1'b1; resp_fin = '0; resp_cnt = 0; resp_block = 3'b010;
    go = 1'b1;
    tick();
    go = 1'b0;
    wait_start_mode(3'd2, "tmo_phase1_start_timeout");
    n = 0;
    while (!error && n < 60) begin tick(); n++; end
    chk("tmo_error_latency", n, 17);
    chk("tmo_error_outputs", {mode, busy, done}, 5'b00000);
    tick(); tick();
    chk("tmo_error_sticky", error, 1'b1);
    resp_block = '0;
    go = 1'b1;
    tick();
    go = 1'b0;
    chk("tmo_go_clears", {error, mode}, 4'b0001);
    wait_done("tmo_rerun_done_timeout");
    tick();

    // Abort coinciding with phase-1 completion
    go = 1'b1;
    tick();
    go = 1'b0;
    wait_start_mode(3'd2, "abort_phase1_start_timeout");
    for (int i = 0; i < 10; i++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_outputs", {mode, busy, phase, done, start}, 9'b000000000);
    for (int i = 0; i < 5; i++) tick();
    chk("abort_no_done", done, 1'b0);

    // Randomized traffic
    resp_lat_rand = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      go = ($urandom_range(0, 9) == 0);
      abort = ($urandom_range(0, 59) == 0);
      key_in = 24'($urandom);
      resp_block = ($urandom_range(0, 7) == 0) ? NP'(1 << $urandom_range(0, NP - 1)) : '0;
      if ($urandom_range(0, 15) == 0) resp_fin = resp_fin ^ NP'($urandom);
      if (i == 1500) begin
        rst_n = 1'b0;
        #1;
        chk("async_reset_mid_run", {mode, busy, start, done, error}, 7'b0000000);
      end
      if (i == 1503) rst_n = 1'b1;
      tick();
    end
    go = 1'b0; abort = 1'b0;
    for (int i = 0; i < 5; i++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1);
  end

endmodule
